// File: rtl/mac_result_packer.sv
// Applies ReLU to MAC dot_product results, packs LANES of them per word and buffers the words
// in a FIFO for a valid/ready write-back stream. Define LEAKY_RELU_EN for leaky ReLU (alpha=1/8).
module mac_result_packer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W*LANES-1:0]    out_data,
    input  logic                       out_ready,
    output logic [ADDR_W:0]            fifo_count,
    output logic                       overflow
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned OUT_W  = DATA_W * LANES;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_lanes [LANES];
    logic [OUT_W-1:0]  r_mem   [DEPTH];
    logic [LANE_W-1:0] r_lane_cnt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic [DATA_W-1:0] w_act;
    logic [OUT_W-1:0]  w_word;
    logic              w_lane_last;
    logic              w_full;
    logic              w_accept;
    logic              w_pop;
    logic              w_push_full;
    logic              w_push_flush;
    logic              w_push;
    logic [LANE_W-1:0] w_lane_cnt_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_overflow_nxt;

    // Activation function
    always_comb begin
`ifdef LEAKY_RELU_EN
        w_act = in_data[DATA_W-1] ? DATA_W'($signed(in_data) >>> 3) : in_data;
`else
        w_act = in_data[DATA_W-1] ? '0 : in_data;
`endif
    end

    // Handshakes, push decision and the word to push (unfilled lanes read as zero)
    always_comb begin
        w_lane_last  = (r_lane_cnt == LANE_W'(LANES - 1));
        w_full       = (r_count == CNT_W'(DEPTH));
        in_ready     = !(w_lane_last && w_full);
        out_valid    = (r_count != '0);
        out_data     = out_valid ? r_mem[r_rd_ptr] : '0;
        fifo_count   = r_count;
        overflow     = r_overflow;
        w_accept     = in_valid && in_ready;
        w_pop        = out_valid && out_ready;
        w_push_full  = w_accept && w_lane_last;
        w_push_flush = flush && !w_push_full && !w_full && ((r_lane_cnt != '0) || w_accept);
        w_push       = w_push_full || w_push_flush;
        w_word       = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (w_accept && (LANE_W'(i) == r_lane_cnt)) begin
                w_word[i*DATA_W +: DATA_W] = w_act;
            end else if (LANE_W'(i) < r_lane_cnt) begin
                w_word[i*DATA_W +: DATA_W] = r_lanes[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_lane_cnt_nxt = r_lane_cnt;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow || (in_valid && !in_ready);
        if (w_push) begin
            w_lane_cnt_nxt = '0;
            w_wr_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
        end else if (w_accept) begin
            w_lane_cnt_nxt = r_lane_cnt + LANE_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        if (clr) begin
            w_lane_cnt_nxt = '0;
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_lane_cnt <= w_lane_cnt_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Data storage needs no reset: lane masking and out_valid gate stale contents
    always_ff @(posedge clk) begin
        if (w_accept && !clr) begin
            r_lanes[r_lane_cnt] <= w_act;
        end
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

endmodule

// File: tb/tb_mac_result_packer.sv
// Directed self-checking bench for mac_result_packer; honours LEAKY_RELU_EN for expected data.
module tb_mac_result_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [3:0]  fifo_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    mac_result_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    // Watchdog against a hung test
    initial begin
        #1000000;
        bad++;
        $error("FAIL timeout: test did not complete within the wait bound");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_count", 64'(fifo_count), 64'(4'd0));
        check("rst_overflow", 64'(overflow), 64'(1'b0));
        check("rst_out_data", out_data, 64'h0);
        #4 rst_n = 1'b1;
        step();

        // Pack with activation
        send(16'h0010); send(16'hFFF0); send(16'h0100);
        check("pack_not_yet", 64'(out_valid), 64'(1'b0));
        send(16'h8000);
        check("pack_valid", 64'(out_valid), 64'(1'b1));
`ifdef LEAKY_RELU_EN
        check("pack_data", out_data, 64'hF000_0100_FFFE_0010);
`else
        check("pack_data", out_data, 64'h0000_0100_0000_0010);
`endif
        check("pack_count", 64'(fifo_count), 64'(4'd1));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("pop_count", 64'(fifo_count), 64'(4'd0));
        check("pop_out_data", out_data, 64'h0);

        // Backpressure
        for (int i = 0; i < 35; i++) send(16'h0001);
        check("bp_count", 64'(fifo_count), 64'(4'd8));
        check("bp_in_ready", 64'(in_ready), 64'(1'b0));
        check("bp_no_ovf_yet", 64'(overflow), 64'(1'b0));
        send(16'h0001);
        check("bp_overflow", 64'(overflow), 64'(1'b1));
        check("bp_count_hold", 64'(fifo_count), 64'(4'd8));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 64'(out_valid), 64'(1'b1));
            check("drain_data", out_data, 64'h0001_0001_0001_0001);
            step();
            if (i == 0) check("drain_in_ready", 64'(in_ready), 64'(1'b1));
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(fifo_count), 64'(4'd0));
        check("drain_ovf_sticky", 64'(overflow), 64'(1'b1));
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_overflow", 64'(overflow), 64'(1'b0));

        // Flush of a partial word, then a flush with nothing pending
        send(16'h0005); send(16'h0007);
        flush = 1'b1; step();
        check("flush_valid", 64'(out_valid), 64'(1'b1));
        check("flush_data", out_data, 64'h0000_0000_0007_0005);
        step(); flush = 1'b0;
        check("flush_idle_count", 64'(fifo_count), 64'(4'd1));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("flush_popped", 64'(fifo_count), 64'(4'd0));

        // Simultaneous push and pop at count 1
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        check("pp_head0", out_data, 64'h0004_0003_0002_0001);
        send(16'h0005); send(16'h0006); send(16'h0007);
        out_ready = 1'b1; send(16'h0008);
        check("pp_count", 64'(fifo_count), 64'(4'd1));
        check("pp_head1", out_data, 64'h0008_0007_0006_0005);
        step(); out_ready = 1'b0;
        check("pp_drained", 64'(fifo_count), 64'(4'd0));

        // Mid-operation async reset
        for (int i = 0; i < 14; i++) send(16'h0009);
        check("mid_count", 64'(fifo_count), 64'(4'd3));
        rst_n = 1'b0; #1;
        check("arst_out_valid", 64'(out_valid), 64'(1'b0));
        check("arst_count", 64'(fifo_count), 64'(4'd0));
        check("arst_out_data", out_data, 64'h0);
        #2 rst_n = 1'b1;
        step();

        // Mid-operation clr overriding same-cycle sample and pop
        for (int i = 0; i < 14; i++) send(16'h0009);
        clr = 1'b1; out_ready = 1'b1; send(16'h0042);
        clr = 1'b0; out_ready = 1'b0;
        check("clr_count", 64'(fifo_count), 64'(4'd0));
        check("clr_out_valid", 64'(out_valid), 64'(1'b0));
        check("clr_in_ready", 64'(in_ready), 64'(1'b1));
        flush = 1'b1; send(16'h0011); flush = 1'b0;
        check("clr_lane0_data", out_data, 64'h0000_0000_0000_0011);
        check("clr_lane0_count", 64'(fifo_count), 64'(4'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
